// File: rtl/fetch_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_seq_pkg
// Purpose  : Shared constants and types for the fetch sequencer: address and
//            instruction widths, opcode field position, opcode and FSM state
//            encodings, and a helper that extracts the opcode field.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_seq_pkg;

  localparam int ADDR_W = 8;
  localparam int INST_W = 10;

  // Opcode field position inside the instruction word.
  localparam int OP_MSB = 9;
  localparam int OP_LSB = 6;

  typedef enum logic [3:0] {
    LHW  = 4'd0,
    ADDI = 4'd1,
    SHW  = 4'd2,
    BEQZ = 4'd3,
    HALT = 4'd15
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;

  function automatic logic [OP_MSB-OP_LSB:0] opcode_of(input logic [INST_W-1:0] word);
    return word[OP_MSB:OP_LSB];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Program counter and fetch controller. Drives the combinational
//            instruction ROM address, captures the returned word into a single
//            registered slot and presents it to decode over valid/ready.
//            Handles branch redirects from execute and parks on HALT.
// Ports    : CLK, reset_n (async, active-low)
//            start, start_addr          - start / restart from an address
//            InstAddress, InstIn        - ROM address out, ROM data in
//            inst_valid, inst_ready     - handshake to decode
//            inst_out, inst_pc          - slot word and the PC it came from
//            branch_taken, branch_target- redirect request from execute
//            halted                     - machine parked on HALT
//            retired_cnt, stall_cnt     - only with FETCH_SEQ_PERF_EN defined
// Config   : FETCH_SEQ_PERF_EN adds saturating retire / stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
  parameter int         ADDR_W  = fetch_seq_pkg::ADDR_W,
  parameter int         INST_W  = fetch_seq_pkg::INST_W,
  parameter logic [3:0] HALT_OP = 4'b1111
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] InstAddress,
  input  logic [INST_W-1:0] InstIn,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              halted
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [15:0]       retired_cnt,
  output logic [15:0]       stall_cnt
`endif
);

  import fetch_seq_pkg::*;

  localparam logic [1:0] c_st_idle   = IDLE;
  localparam logic [1:0] c_st_run    = RUN;
  localparam logic [1:0] c_st_halted = HALTED;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_valid;
  logic [INST_W-1:0] r_inst;
  logic [ADDR_W-1:0] r_inst_pc;
  logic              r_halted;

  logic w_run;
  logic w_accept;
  logic w_halt_held;
  logic w_load;

  assign w_run       = (r_state == c_st_run);
  // Slot may be overwritten when empty or when decode takes it this cycle.
  assign w_accept    = ~r_valid | inst_ready;
  // A held HALT word blocks further fetch until it is consumed or flushed.
  assign w_halt_held = r_valid & (opcode_of(r_inst) == HALT_OP);
  assign w_load      = w_run & ~branch_taken & ~w_halt_held & w_accept;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= c_st_idle;
      r_pc      <= '0;
      r_valid   <= 1'b0;
      r_inst    <= '0;
      r_inst_pc <= '0;
      r_halted  <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (start) begin
            r_pc    <= start_addr;
            r_state <= c_st_run;
          end
        end
        c_st_run: begin
          if (branch_taken) begin
            // Redirect wins over everything, including a pending HALT and a
            // simultaneous decode accept: the slot is simply discarded.
            r_pc    <= branch_target;
            r_valid <= 1'b0;
          end else if (w_halt_held) begin
            if (inst_ready) begin
              r_valid  <= 1'b0;
              r_halted <= 1'b1;
              r_state  <= c_st_halted;
            end
          end else if (w_load) begin
            r_inst    <= InstIn;
            r_inst_pc <= r_pc;
            r_valid   <= 1'b1;
            r_pc      <= r_pc + ADDR_W'(1);
          end
        end
        c_st_halted: begin
          if (start) begin
            r_pc     <= start_addr;
            r_halted <= 1'b0;
            r_state  <= c_st_run;
          end
        end
        default: begin
          r_state <= c_st_idle;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign InstAddress = r_pc;
  assign inst_valid  = r_valid;
  assign inst_out    = r_inst;
  assign inst_pc     = r_inst_pc;
  assign halted      = r_halted;

`ifdef FETCH_SEQ_PERF_EN
  logic [15:0] r_retired_cnt;
  logic [15:0] r_stall_cnt;
  logic        w_restart;
  logic        w_retire;
  logic        w_stall;

  // Counters restart only when a start is actually honoured.
  assign w_restart = start & ((r_state == c_st_idle) | (r_state == c_st_halted));
  assign w_retire  = w_run & r_valid & inst_ready & ~branch_taken;
  assign w_stall   = w_run & r_valid & ~inst_ready;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_retired_cnt <= '0;
      r_stall_cnt   <= '0;
    end else if (w_restart) begin
      r_retired_cnt <= '0;
      r_stall_cnt   <= '0;
    end else begin
      if (w_retire && (r_retired_cnt != 16'hFFFF)) begin
        r_retired_cnt <= r_retired_cnt + 16'd1;
      end
      if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign retired_cnt = r_retired_cnt;
  assign stall_cnt   = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Purpose  : Self-checking bench for fetch_sequencer. Cycle table for the main
//            program flow, scoreboard of accepted instructions, and directed
//            sequences for wrap, asynchronous reset and the perf counters
//            (the latter only when FETCH_SEQ_PERF_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;
  import fetch_seq_pkg::*;

  logic              CLK = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W-1:0] InstAddress;
  logic [INST_W-1:0] InstIn;
  logic              inst_valid;
  logic              inst_ready = 1'b0;
  logic [INST_W-1:0] inst_out;
  logic [ADDR_W-1:0] inst_pc;
  logic              branch_taken = 1'b0;
  logic [ADDR_W-1:0] branch_target = '0;
  logic              halted;
`ifdef FETCH_SEQ_PERF_EN
  logic [15:0]       retired_cnt;
  logic [15:0]       stall_cnt;
`endif

  logic [INST_W-1:0] rom [256];
  assign InstIn = rom[InstAddress];

  fetch_sequencer dut (
    .CLK           (CLK),
    .reset_n       (reset_n),
    .start         (start),
    .start_addr    (start_addr),
    .InstAddress   (InstAddress),
    .InstIn        (InstIn),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_out      (inst_out),
    .inst_pc       (inst_pc),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halted        (halted)
`ifdef FETCH_SEQ_PERF_EN
    ,
    .retired_cnt   (retired_cnt),
    .stall_cnt     (stall_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic              st;
    logic [ADDR_W-1:0] sa;
    logic              rdy;
    logic              br;
    logic [ADDR_W-1:0] tgt;
    logic              ev;
    logic [ADDR_W-1:0] epc;
    logic [ADDR_W-1:0] eaddr;
    logic              eh;
  } vec_t;
  vec_t tv[22];

  function automatic vec_t v(input logic st, input int sa, input logic rdy,
                             input logic br, input int tgt, input logic ev,
                             input int epc, input int eaddr, input logic eh);
    vec_t r;
    r.st = st; r.sa = ADDR_W'(sa); r.rdy = rdy; r.br = br; r.tgt = ADDR_W'(tgt);
    r.ev = ev; r.epc = ADDR_W'(epc); r.eaddr = ADDR_W'(eaddr); r.eh = eh;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input int pc);
    exp_t e;
    e.pc   = ADDR_W'(pc);
    e.inst = rom[pc];
    sbq.push_back(e);
  endtask

  // Scoreboard: every completed handshake must match the next expected word.
  always @(negedge CLK) begin
    exp_t e;
    if (reset_n && inst_valid && inst_ready && !branch_taken) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected actual_pc=%0d required=none", inst_pc);
      end else begin
        e = sbq.pop_front();
        if (inst_pc !== e.pc || inst_out !== e.inst) begin
          failures++;
          $display("FAIL sb_handshake actual pc=%0d inst=%h required pc=%0d inst=%h",
                   inst_pc, inst_out, e.pc, e.inst);
        end
      end
    end
  end

  initial begin
    logic pv;
    logic [ADDR_W-1:0] ppc;
    bit seen;

    for (int i = 0; i < 256; i++) rom[i] = '0;
    rom[0] = 10'b0000000001;
    rom[1] = 10'b0001001001;
    rom[2] = 10'b0010000001;
    rom[3] = 10'b0011001001;
    rom[4] = 10'b1111111111;

    // ---------------- reset state ----------------
    repeat (2) tick();
    chk("rst_valid",  32'(inst_valid), 0);
    chk("rst_addr",   32'(InstAddress), 0);
    chk("rst_pc",     32'(inst_pc), 0);
    chk("rst_inst",   32'(inst_out), 0);
    chk("rst_halted", 32'(halted), 0);
`ifdef FETCH_SEQ_PERF_EN
    chk("rst_retired", 32'(retired_cnt), 0);
    chk("rst_stall",   32'(stall_cnt), 0);
`endif
    reset_n = 1'b1;

    // ---------------- cycle table ----------------
    //            st sa  rdy br tgt ev pc addr h
    tv[0]  = v(1, 0, 1, 0, 0, 0, 0, 0, 0);  // start from 0
    tv[1]  = v(0, 0, 1, 0, 0, 1, 0, 1, 0);
    tv[2]  = v(0, 0, 1, 0, 0, 1, 1, 2, 0);
    tv[3]  = v(0, 0, 1, 0, 0, 1, 2, 3, 0);
    tv[4]  = v(0, 0, 0, 0, 0, 1, 2, 3, 0);  // backpressure x3
    tv[5]  = v(0, 0, 0, 0, 0, 1, 2, 3, 0);
    tv[6]  = v(0, 0, 0, 0, 0, 1, 2, 3, 0);
    tv[7]  = v(0, 0, 1, 0, 0, 1, 3, 4, 0);
    tv[8]  = v(0, 0, 1, 0, 0, 1, 4, 5, 0);  // halt word in slot
    tv[9]  = v(0, 0, 1, 0, 0, 0, 0, 5, 1);  // halt accepted
    tv[10] = v(0, 0, 1, 0, 0, 0, 0, 5, 1);
    tv[11] = v(1, 3, 1, 0, 0, 0, 0, 3, 0);  // restart from HALTED
    tv[12] = v(0, 0, 1, 0, 0, 1, 3, 4, 0);
    tv[13] = v(0, 0, 1, 0, 0, 1, 4, 5, 0);
    tv[14] = v(0, 0, 0, 0, 0, 1, 4, 5, 0);  // halt held, no fetch
    tv[15] = v(0, 0, 1, 1, 1, 0, 0, 1, 0);  // branch flushes halt
    tv[16] = v(0, 0, 1, 0, 0, 1, 1, 2, 0);
    tv[17] = v(0, 0, 1, 0, 0, 1, 2, 3, 0);
    tv[18] = v(0, 0, 1, 1, 4, 0, 0, 4, 0);  // branch beats ready
    tv[19] = v(0, 0, 1, 0, 0, 1, 4, 5, 0);
    tv[20] = v(0, 0, 1, 0, 0, 0, 0, 5, 1);
    tv[21] = v(0, 0, 1, 1, 7, 0, 0, 5, 1);  // branch ignored in HALTED

    pv  = 1'b0;
    ppc = '0;
    for (int i = 0; i < 22; i++) begin
      if (tv[i].rdy && !tv[i].br && pv) push(int'(ppc));
      pv  = tv[i].ev;
      ppc = tv[i].epc;
      start         = tv[i].st;
      start_addr    = tv[i].sa;
      inst_ready    = tv[i].rdy;
      branch_taken  = tv[i].br;
      branch_target = tv[i].tgt;
      tick();
      chk($sformatf("tv%0d_valid", i),  32'(inst_valid), 32'(tv[i].ev));
      chk($sformatf("tv%0d_addr", i),   32'(InstAddress), 32'(tv[i].eaddr));
      chk($sformatf("tv%0d_halted", i), 32'(halted), 32'(tv[i].eh));
      if (tv[i].ev) chk($sformatf("tv%0d_pc", i), 32'(inst_pc), 32'(tv[i].epc));
    end
    start = 1'b0; branch_taken = 1'b0; inst_ready = 1'b0;
    chk("tv_drain", 32'(sbq.size()), 0);
`ifdef FETCH_SEQ_PERF_EN
    chk("tv_retired", 32'(retired_cnt), 3);
    chk("tv_stall",   32'(stall_cnt), 1);
`endif

    // ---------------- wrap, branch ignored in IDLE ----------------
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    branch_taken = 1'b1; branch_target = 8'd9;
    tick();
    branch_taken = 1'b0;
    chk("idle_br_addr",  32'(InstAddress), 0);
    chk("idle_br_valid", 32'(inst_valid), 0);
    start = 1'b1; start_addr = 8'd254;
    tick();
    start = 1'b0;
    push(254); push(255); push(0); push(1);
    inst_ready = 1'b1;
    repeat (5) tick();
    inst_ready = 1'b0;
    chk("wrap_valid", 32'(inst_valid), 1);
    chk("wrap_pc",    32'(inst_pc), 2);
    chk("wrap_addr",  32'(InstAddress), 3);
    chk("wrap_drain", 32'(sbq.size()), 0);

    // start while running is ignored
    start = 1'b1; start_addr = 8'd50;
    tick();
    start = 1'b0;
    chk("run_start_addr", 32'(InstAddress), 3);
    chk("run_start_pc",   32'(inst_pc), 2);

    // ---------------- asynchronous reset mid-RUN ----------------
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid",  32'(inst_valid), 0);
    chk("arst_addr",   32'(InstAddress), 0);
    chk("arst_pc",     32'(inst_pc), 0);
    chk("arst_inst",   32'(inst_out), 0);
    chk("arst_halted", 32'(halted), 0);
    tick();
    reset_n = 1'b1;
    start = 1'b1; start_addr = 8'd2;
    tick();
    start = 1'b0;
    chk("arst_start_valid", 32'(inst_valid), 0);
    chk("arst_start_addr",  32'(InstAddress), 2);
    push(2);
    inst_ready = 1'b1;
    tick();
    chk("arst_first_valid", 32'(inst_valid), 1);
    chk("arst_first_pc",    32'(inst_pc), 2);
    tick();
    inst_ready = 1'b0;
    chk("arst_second_pc", 32'(inst_pc), 3);
    chk("arst_drain",     32'(sbq.size()), 0);

`ifdef FETCH_SEQ_PERF_EN
    // ---------------- perf counters with a 2-cycle stall ----------------
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int p = 0; p < 5; p++) push(p);
    start = 1'b1; start_addr = 8'd0; inst_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    inst_ready = 1'b0;
    repeat (2) tick();
    inst_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (halted) seen = 1'b1;
    end
    chk("perf_halt_seen", 32'(seen), 1);
    chk("perf_retired",   32'(retired_cnt), 5);
    chk("perf_stall",     32'(stall_cnt), 2);
    chk("perf_drain",     32'(sbq.size()), 0);
    inst_ready = 1'b0;
`else
    seen = 1'b0;
`endif

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Program-counter and fetch controller that drives the combinational instruction ROM address and presents fetched words to the decode stage over a valid/ready handshake. Owns the PC, applies branch redirects from execute, detects the halt opcode and parks the machine. Sits between the instruction ROM and the decode/execute datapath. Holds one registered instruction slot.

Parameters:
ADDR_W, 8, PC / ROM address width
INST_W, 10, instruction width: [9:6] opcode, [5:3] rs/rt, [2:0] rt/imm/target
HALT_OP, 4'b1111, opcode that stops fetch

Ports:
CLK  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
start  in  1  pulse; starts or restarts execution from start_addr
start_addr  in  ADDR_W  first fetch address
InstAddress  out  ADDR_W  ROM address; always equals the PC register
InstIn  in  INST_W  ROM data, combinational from InstAddress
inst_valid  out  1  inst_out/inst_pc hold a live instruction
inst_ready  in  1  decode accepts the instruction this cycle
inst_out  out  INST_W  registered instruction word
inst_pc  out  ADDR_W  address inst_out was fetched from
branch_taken  in  1  redirect request from execute
branch_target  in  ADDR_W  absolute redirect address
halted  out  1  high in HALTED state

Behaviour:
- Reset is asynchronous and active-low. During reset: state=IDLE, PC=0, inst_valid=0, inst_out=0, inst_pc=0, halted=0.
- States: IDLE, RUN, HALTED.
- IDLE: no fetch; inst_valid=0. When start=1: PC<=start_addr and go to RUN.
- RUN: the slot loads when inst_valid=0 or inst_ready=1 (the accept condition), and no halt word is held.
  - On load: inst_out<=InstIn, inst_pc<=PC, inst_valid<=1, PC<=PC+1.
  - The PC wraps modulo 2^ADDR_W (255+1=0).
  - If neither condition holds, the slot, inst_valid and PC hold (stall).
- Latency: the first instruction is valid 1 cycle after the start edge. Steady-state throughput is 1 instruction/cycle while inst_ready=1.
- Halt: once the slot holds opcode==HALT_OP, no further fetch and PC holds. When the halt word is accepted (inst_ready=1): inst_valid<=0, state<=HALTED, halted<=1.
- Branch: branch_taken=1 in RUN has the highest priority.
  - PC<=branch_target, inst_valid<=0, and any slot contents are flushed, including a held halt word.
  - The target instruction is valid 1 cycle after the redirect edge.
  - branch_taken together with inst_ready: the branch wins and the slot is flushed, not loaded.
- branch_taken is ignored in IDLE and HALTED.
- start in RUN is ignored. start in HALTED: PC<=start_addr, halted<=0, state<=RUN.
- Asserting reset mid-operation returns to the reset values immediately; no partial fetch survives.
- InstAddress is a direct copy of the PC register; it has no combinational path from any input.

Optional Feature:
FETCH_SEQ_PERF_EN:
- Defined: adds outputs retired_cnt[15:0] and stall_cnt[15:0], both reset to 0 and restarted to 0 on start.
  - retired_cnt increments on each accepted handshake (inst_valid&inst_ready, not flushed).
  - stall_cnt increments on each RUN cycle with inst_valid=1 and inst_ready=0.
  - Both counters saturate at 16'hFFFF.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package fetch_seq_pkg holds:
  - ADDR_W and INST_W constants.
  - Opcode enum: LHW=0, ADDI=1, SHW=2, BEQZ=3, HALT=15.
  - Field-slice constants: OP_MSB=9, OP_LSB=6.
  - State enum: IDLE, RUN, HALTED.
- No sub-module is needed; the slot register, PC and FSM live in one module. The perf counters are inline under the macro.

Test Plan:
- Straight line, ROM {0:0000000001, 1:0001001001, 2:0010000001, 3:0011001001, 4:1111111111}, start_addr=0, inst_ready=1 -> inst_pc 0,1,2,3,4 on consecutive cycles; halted=1 the cycle after pc 4 is accepted; InstAddress stays 5.
- Backpressure: inst_ready=0 for 3 cycles while holding pc 2 -> inst_out/inst_pc/InstAddress stable (2/2/3); resumes with pc 3 the cycle after inst_ready=1.
- Branch: branch_taken=1, target=1 while the slot holds pc 4 (halt) -> halt flushed, inst_valid=0 for 1 cycle, then inst_pc=1; halted never asserts.
- Wrap: start_addr=254, inst_ready=1, default ROM words -> inst_pc 254,255,0,1.
- Reset mid-RUN with inst_valid=1 -> inst_valid=0, InstAddress=0, state IDLE asynchronously; start with start_addr=2 -> inst_pc=2 the next cycle.
- FETCH_SEQ_PERF_EN, program above with a 2-cycle stall -> retired_cnt=5, stall_cnt=2 at halt.
